// File: rtl/id_stage.sv
// Decode stage of the 4-stage 8-bit pipeline: instruction decode, 8x8 register
// file with WB write-through bypass, and EX-stage operand hazard flags.
module id_stage #(
   parameter int NREG = 8,
   parameter int W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   Instr,
   input  logic         ID_EX_RegWrite,
   input  logic [2:0]   ID_EX_Reg,
   input  logic         WB_RegWrite,
   input  logic [2:0]   WB_Reg,
   input  logic [W-1:0] WB_Data,
   output logic         RegWrite,
   output logic         ALUOp,
   output logic [W-1:0] Data1,
   output logic [W-1:0] Data2,
   output logic [2:0]   WriteRegNum,
   output logic         Fwd1,
   output logic         Fwd2
);

   logic [W-1:0] r_regs [NREG];

   logic [1:0]   w_opcode;
   logic [2:0]   w_rs1;
   logic [2:0]   w_rs2;
   logic         w_regwrite;
   logic         w_aluop;
   logic [W-1:0] w_rd1;
   logic [W-1:0] w_rd2;
   logic         w_fwd1;
   logic         w_fwd2;

   assign w_opcode = Instr[7:6];
   assign w_rs1    = Instr[5:3];
   assign w_rs2    = Instr[2:0];

   // Register file: reset loads each entry with its own index; reset beats WB.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= W'(i);
         end
      end else if (WB_RegWrite) begin
         r_regs[WB_Reg] <= WB_Data;
      end
   end

   // Opcode decode.
   always_comb begin
      w_regwrite = 1'b0;
      w_aluop    = 1'b0;
      case (w_opcode)
         2'b00: begin
            w_regwrite = 1'b1;
            w_aluop    = 1'b0;
         end
         2'b01: begin
            w_regwrite = 1'b1;
            w_aluop    = 1'b1;
         end
         default: begin
            w_regwrite = 1'b0;
            w_aluop    = 1'b0;
         end
      endcase
   end

   // Read ports with write-through so a producer two ahead needs no stall.
   always_comb begin
      w_rd1 = r_regs[w_rs1];
      w_rd2 = r_regs[w_rs2];
      if (WB_RegWrite && (WB_Reg == w_rs1)) begin
         w_rd1 = WB_Data;
      end else begin
         w_rd1 = r_regs[w_rs1];
      end
      if (WB_RegWrite && (WB_Reg == w_rs2)) begin
         w_rd2 = WB_Data;
      end else begin
         w_rd2 = r_regs[w_rs2];
      end
   end

   assign w_fwd1 = ID_EX_RegWrite & w_regwrite & (ID_EX_Reg == w_rs1);
   assign w_fwd2 = ID_EX_RegWrite & w_regwrite & (ID_EX_Reg == w_rs2);

   // Output stage: everything held at zero while reset is asserted.
   always_comb begin
      RegWrite    = 1'b0;
      ALUOp       = 1'b0;
      Data1       = '0;
      Data2       = '0;
      WriteRegNum = 3'd0;
      Fwd1        = 1'b0;
      Fwd2        = 1'b0;
      if (rst) begin
         RegWrite    = w_regwrite;
         ALUOp       = w_aluop;
         Data1       = w_rd1;
         Data2       = w_rd2;
         WriteRegNum = w_rs1;
         Fwd1        = w_fwd1;
         Fwd2        = w_fwd2;
      end else begin
         RegWrite    = 1'b0;
         ALUOp       = 1'b0;
         Data1       = '0;
         Data2       = '0;
         WriteRegNum = 3'd0;
         Fwd1        = 1'b0;
         Fwd2        = 1'b0;
      end
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage of the 4-stage 8-bit pipeline (IF, ID, EX, WB). Sits between the IF/ID register and the ID/EX register. It decodes the 8-bit instruction, reads two operands from an 8-entry x 8-bit register file, and accepts the register write-back from the WB stage. It also flags EX-stage operand hazards so the EX stage can forward its result.

## Interface
Parameters:
- `NREG`, 8: register file depth. Fixed by the 3-bit register fields.
- `W`, 8: data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `Instr`  in  8  instruction from IF/ID. [7:6] opcode, [5:3] rd/rs1, [2:0] rs2.
- `ID_EX_RegWrite`  in  1  RegWrite of the instruction currently in EX.
- `ID_EX_Reg`  in  3  destination register of the instruction currently in EX.
- `WB_RegWrite`  in  1  write enable from the WB stage.
- `WB_Reg`  in  3  write-back register number.
- `WB_Data`  in  8  write-back data.
- `RegWrite`  out  1  decoded write enable, to ID/EX.
- `ALUOp`  out  1  0 = ADD, 1 = SLL (Data1 << Data2[2:0]), to ID/EX.
- `Data1`  out  8  operand read from rs1 (= rd).
- `Data2`  out  8  operand read from rs2.
- `WriteRegNum`  out  3  destination register, equal to Instr[5:3].
- `Fwd1`  out  1  rs1 matches the destination of the instruction in EX.
- `Fwd2`  out  1  rs2 matches the destination of the instruction in EX.

## Operation
- Decode is combinational from `Instr`:
  - opcode 00 (ADD): RegWrite=1, ALUOp=0.
  - opcode 01 (SLL): RegWrite=1, ALUOp=1.
  - opcode 10 and 11 (NOP): RegWrite=0, ALUOp=0.
- `WriteRegNum` = Instr[5:3] for all opcodes.
- Register file: 8 x 8-bit flops, two asynchronous read ports and one write port.
- Write rule: on posedge `clk` with `rst`=1 and `WB_RegWrite`=1, reg[`WB_Reg`] <= `WB_Data`. All 8 registers are writable, including reg0.
- Write-through bypass applies when `WB_RegWrite`=1 and `WB_Reg` equals a source field in the same cycle. The matching Data output then equals `WB_Data`, not the stale array value. Both ports bypass independently.
- Hazard flags:
  - Fwd1 = ID_EX_RegWrite & RegWrite & (ID_EX_Reg == Instr[5:3]).
  - Fwd2 = ID_EX_RegWrite & RegWrite & (ID_EX_Reg == Instr[2:0]).
  - A NOP in ID never raises either flag.
- When a flag is set, EX substitutes its own ALU result for that operand. Data1/Data2 still carry the register-file value.
- Arithmetic is not performed here. All data is unsigned 8-bit.

## Timing
- Reset: on posedge `clk` with `rst`=0, reg[i] <= i for i = 0..7. A WB write in the same cycle is discarded, because reset has priority.
- While `rst`=0, every output is forced to 0: RegWrite, ALUOp, Data1, Data2, WriteRegNum, Fwd1, Fwd2.
- Reset asserted mid-operation: the register file is restored to index values at the next edge. In-flight WB data is lost.
- Read latency is 0 cycles: outputs are valid within the same cycle `Instr` changes. The ID/EX register captures them at the next edge.
- Write latency is 1 edge; same-cycle visibility comes through the bypass.
- Data-hazard coverage:
  - Distance 1 (producer in EX): handled by Fwd1/Fwd2.
  - Distance 2 (producer in WB): handled by the bypass.
  - Distance 3 or more: the value is already in the array.
- No stalls are ever required.
- A write and a read of the same register with different source fields: both Data outputs reflect `WB_Data` where matched.
- When rs1 == rs2, Data1 == Data2 always, with or without bypass.

## Test plan
- Reset: hold `rst`=0 for 2 edges, then release.
  - During reset, all outputs must read 0.
  - After release, `Instr`=8'b00_011_101 must give Data1=3, Data2=5, RegWrite=1, ALUOp=0, WriteRegNum=3.
- Write then read: WB writes reg2=8'hA5 at one edge. The next cycle, `Instr`=8'b01_010_010 must give Data1=Data2=8'hA5 and ALUOp=1.
- Bypass: in the same cycle, WB_RegWrite=1, WB_Reg=4, WB_Data=8'h3C, and `Instr`=8'b00_001_100. Required: Data2=8'h3C and Data1=1.
- Forward flags:
  - ID_EX_RegWrite=1, ID_EX_Reg=6, `Instr`=8'b00_110_110: Fwd1=Fwd2=1.
  - Same inputs with ID_EX_RegWrite=0: both flags 0.
  - Same inputs with opcode 10: both flags 0 and RegWrite=0.
- Reset priority: WB writes reg7=8'hFF on the same edge as `rst`=0. After release, reading reg7 must give 7.
- Back-to-back writes: WB writes reg0=1, 2, 3 on three consecutive edges while ID reads reg0. Data1 must track 1, 2, 3 in the same cycles, via the bypass.
